pipe_perf_monitor: RTL and testbench

In-core performance monitor for the 5-stage pipelined CPU. It sits alongside the hazard-detection unit and the IF/ID register, consumes their stall and flush indications plus the PC, and keeps cycle, stall, flush and longest-stall-run counters in hardware. Simulation benches and a future debug port read these registers instead of recomputing the same events themselves. It also produces a run-complete flag after a programmable cycle budget.

---
 rtl/pipe_perf_monitor.sv | 131 +++++++++++++
 tb/tb_pipe_perf_monitor.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/pipe_perf_monitor.sv
// Pipeline performance monitor: counts cycles, qualified stalls, deferred flushes and the longest
// stall run over a fixed cycle budget, then freezes until cleared.
module pipe_perf_monitor #(
  parameter int unsigned CNT_W      = 32,
  parameter int unsigned MAX_CYCLES = 200
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             start_i,
  input  logic             clr_i,
  input  logic             stall_req_i,
  input  logic             jump_i,
  input  logic             branch_i,
  input  logic             flush_i,
  input  logic [31:0]      pc_i,
  output logic [CNT_W-1:0] cycle_o,
  output logic [CNT_W-1:0] stall_o,
  output logic [CNT_W-1:0] flush_o,
  output logic [CNT_W-1:0] max_stall_run_o,
  output logic [31:0]      last_pc_o,
  output logic             running_o,
  output logic             done_o
);

  localparam logic [CNT_W-1:0] MaxCyc = CNT_W'(MAX_CYCLES);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           r_state, w_state_d;
  logic [CNT_W-1:0] r_cycle, w_cycle_d;
  logic [CNT_W-1:0] r_stall, w_stall_d;
  logic [CNT_W-1:0] r_flush, w_flush_d;
  logic [CNT_W-1:0] r_max_run, w_max_run_d;
  logic [CNT_W-1:0] r_run, w_run_d;
  logic [31:0]      r_last_pc, w_last_pc_d;
  logic             r_pend, w_pend_d;

  logic             w_stall_ev;
  logic [CNT_W-1:0] w_cycle_inc;
  logic [CNT_W-1:0] w_run_inc;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

  // A stall that coincides with a branch/jump is a control bubble, not a data hazard.
  assign w_stall_ev  = stall_req_i & ~jump_i & ~branch_i;
  assign w_cycle_inc = sat_inc(r_cycle);
  assign w_run_inc   = sat_inc(r_run);

  always_comb begin
    w_state_d   = r_state;
    w_cycle_d   = r_cycle;
    w_stall_d   = r_stall;
    w_flush_d   = r_flush;
    w_max_run_d = r_max_run;
    w_run_d     = r_run;
    w_last_pc_d = r_last_pc;
    w_pend_d    = r_pend;

    if (clr_i) begin
      w_state_d   = StIdle;
      w_cycle_d   = '0;
      w_stall_d   = '0;
      w_flush_d   = '0;
      w_max_run_d = '0;
      w_run_d     = '0;
      w_last_pc_d = '0;
      w_pend_d    = 1'b0;
    end else begin
      case (r_state)
        StIdle: begin
          if (start_i) w_state_d = StRun;
        end
        StRun: begin
          if (start_i) begin
            w_cycle_d   = w_cycle_inc;
            w_last_pc_d = pc_i;
            if (w_stall_ev) begin
              w_stall_d = sat_inc(r_stall);
              w_run_d   = w_run_inc;
              if (w_run_inc > r_max_run) w_max_run_d = w_run_inc;
            end else begin
              w_run_d = '0;
            end
            if (r_pend) w_flush_d = sat_inc(r_flush);
            w_pend_d = flush_i;
            // Final counted edge: a flush armed now can never be counted.
            if (w_cycle_inc == MaxCyc) begin
              w_state_d = StDone;
              w_pend_d  = 1'b0;
            end
          end
        end
        StDone: ;
        default: w_state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state   <= StIdle;
      r_cycle   <= '0;
      r_stall   <= '0;
      r_flush   <= '0;
      r_max_run <= '0;
      r_run     <= '0;
      r_last_pc <= '0;
      r_pend    <= 1'b0;
    end else begin
      r_state   <= w_state_d;
      r_cycle   <= w_cycle_d;
      r_stall   <= w_stall_d;
      r_flush   <= w_flush_d;
      r_max_run <= w_max_run_d;
      r_run     <= w_run_d;
      r_last_pc <= w_last_pc_d;
      r_pend    <= w_pend_d;
    end
  end

  assign cycle_o         = r_cycle;
  assign stall_o         = r_stall;
  assign flush_o         = r_flush;
  assign max_stall_run_o = r_max_run;
  assign last_pc_o       = r_last_pc;
  assign running_o       = (r_state == StRun);
  assign done_o          = (r_state == StDone);

endmodule

// File: tb/tb_pipe_perf_monitor.sv
// Directed bench for pipe_perf_monitor: a default instance (200-cycle budget) and a narrow
// 4-bit instance for the saturation boundary.
module tb_pipe_perf_monitor;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, clr, stall_req, jump, branch, flush;
  logic [31:0] pc;
  logic [31:0] cycle, stall_cnt, flush_cnt, max_run, last_pc;
  logic        running, done;

  logic        start_b, stall_b;
  logic [3:0]  b_cycle, b_stall, b_flush, b_max_run;
  logic [31:0] b_last_pc;
  logic        b_running, b_done;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pipe_perf_monitor #(.CNT_W(32), .MAX_CYCLES(200)) u_dut (
    .clk_i          (clk),
    .rst_n_i        (rst_n),
    .start_i        (start),
    .clr_i          (clr),
    .stall_req_i    (stall_req),
    .jump_i         (jump),
    .branch_i       (branch),
    .flush_i        (flush),
    .pc_i           (pc),
    .cycle_o        (cycle),
    .stall_o        (stall_cnt),
    .flush_o        (flush_cnt),
    .max_stall_run_o(max_run),
    .last_pc_o      (last_pc),
    .running_o      (running),
    .done_o         (done)
  );

  pipe_perf_monitor #(.CNT_W(4), .MAX_CYCLES(15)) u_dut_narrow (
    .clk_i          (clk),
    .rst_n_i        (rst_n),
    .start_i        (start_b),
    .clr_i          (1'b0),
    .stall_req_i    (stall_b),
    .jump_i         (1'b0),
    .branch_i       (1'b0),
    .flush_i        (1'b0),
    .pc_i           (32'h0),
    .cycle_o        (b_cycle),
    .stall_o        (b_stall),
    .flush_o        (b_flush),
    .max_stall_run_o(b_max_run),
    .last_pc_o      (b_last_pc),
    .running_o      (b_running),
    .done_o         (b_done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; clr = 1'b0; stall_req = 1'b0; jump = 1'b0; branch = 1'b0;
    flush = 1'b0; pc = '0; start_b = 1'b0; stall_b = 1'b0;
    #12;
    check("rst_cycle", cycle, 0);
    check("rst_running", {31'd0, running}, 0);
    check("rst_done", {31'd0, done}, 0);
    rst_n = 1'b1;

    repeat (10) tick();
    check("idle_running", {31'd0, running}, 0);
    check("idle_cycle", cycle, 0);

    start = 1'b1;
    tick();
    check("start_running", {31'd0, running}, 1);
    check("start_nocount", cycle, 0);

    for (int n = 1; n <= 20; n++) begin
      stall_req = (n <= 3) || (n >= 5 && n <= 11);
      branch    = (n == 10);
      jump      = (n == 11);
      flush     = (n == 12) || (n >= 14 && n <= 17) || (n == 20);
      pc        = 32'(n * 4);
      tick();
      if (n == 9) begin
        check("stall_3_1_5", stall_cnt, 8);
        check("max_run_5", max_run, 5);
      end
      if (n == 11) begin
        check("stall_br_jmp_ignored", stall_cnt, 8);
        check("max_run_hold", max_run, 5);
      end
      if (n == 12) check("flush_not_yet", flush_cnt, 0);
      if (n == 13) check("flush_k_plus_1", flush_cnt, 1);
      if (n == 17) check("flush_burst_mid", flush_cnt, 4);
      if (n == 18) check("flush_burst_done", flush_cnt, 5);
    end
    check("cycle_20", cycle, 20);

    // Pause with a flush pending; inputs toggled during the gap must be ignored.
    start = 1'b0; stall_req = 1'b1; flush = 1'b1; pc = 32'hDEAD;
    repeat (7) tick();
    check("pause_cycle", cycle, 20);
    check("pause_stall", stall_cnt, 8);
    check("pause_flush", flush_cnt, 5);
    check("pause_pc", last_pc, 80);
    check("pause_running", {31'd0, running}, 1);

    start = 1'b1; stall_req = 1'b0; flush = 1'b0; pc = 84;
    tick();
    check("resume_flush", flush_cnt, 6);
    check("resume_cycle", cycle, 21);

    for (int n = 22; n <= 200; n++) begin
      flush = (n == 199) || (n == 200);
      pc    = 32'(n * 4);
      tick();
      if (n == 199) check("pre_done", {31'd0, done}, 0);
    end
    check("final_cycle", cycle, 200);
    check("final_done", {31'd0, done}, 1);
    check("final_running", {31'd0, running}, 0);
    check("final_flush", flush_cnt, 7);
    check("final_pc", last_pc, 800);
    check("final_stall", stall_cnt, 8);

    flush = 1'b0; stall_req = 1'b1;
    repeat (20) tick();
    check("frozen_cycle", cycle, 200);
    check("frozen_flush", flush_cnt, 7);
    check("frozen_stall", stall_cnt, 8);
    check("frozen_done", {31'd0, done}, 1);

    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("clr_done", {31'd0, done}, 0);
    check("clr_running", {31'd0, running}, 0);
    check("clr_cycle", cycle, 0);
    check("clr_flush", flush_cnt, 0);
    check("clr_stall", stall_cnt, 0);
    check("clr_max", max_run, 0);
    check("clr_pc", last_pc, 0);

    tick();
    check("restart_running", {31'd0, running}, 1);
    repeat (5) tick();
    check("restart_stall", stall_cnt, 5);
    check("restart_max", max_run, 5);
    check("restart_cycle", cycle, 5);

    #3 rst_n = 1'b0;
    #1;
    check("async_cycle", cycle, 0);
    check("async_stall", stall_cnt, 0);
    check("async_max", max_run, 0);
    check("async_pc", last_pc, 0);
    check("async_running", {31'd0, running}, 0);
    #2 rst_n = 1'b1;
    start = 1'b0; stall_req = 1'b0;

    start_b = 1'b1; stall_b = 1'b1;
    repeat (20) tick();
    check("sat_cycle", 32'(b_cycle), 15);
    check("sat_stall", 32'(b_stall), 15);
    check("sat_max", 32'(b_max_run), 15);
    check("sat_done", {31'd0, b_done}, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
